reorder_buffer: RTL and testbench

- Circular in-order reorder buffer with NUM_ROB_ENTRY slots; sits next to register_status.
- At dispatch it allocates the ROB index that register_status records as renaming_rob_index_in.
- At commit it retires the head entry in order and drives register_status release_valid_in, release_name_in and release_rob_index_in.
- It also serves result lookups for operands whose producer is still in flight.

---
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates slots at dispatch, collects results at
// writeback and retires the head in program order, serving operand lookups.
module reorder_buffer #(
  parameter int NUM_ROB_ENTRY = 6,
  parameter int NUM_GENERAL_PURPOSE_REGISTER = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ_PORT = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic flush_in,
  input  logic dispatch_valid_in,
  output logic dispatch_ready_out,
  input  logic dispatch_has_dest_in,
  input  logic [$clog2(NUM_GENERAL_PURPOSE_REGISTER)-1:0] dispatch_dest_name_in,
  output logic [$clog2(NUM_ROB_ENTRY)-1:0] dispatch_rob_index_out,
  input  logic writeback_valid_in,
  input  logic [$clog2(NUM_ROB_ENTRY)-1:0] writeback_rob_index_in,
  input  logic [DATA_WIDTH-1:0] writeback_data_in,
  input  logic commit_ready_in,
  output logic commit_valid_out,
  output logic [DATA_WIDTH-1:0] commit_data_out,
  output logic release_valid_out,
  output logic [$clog2(NUM_GENERAL_PURPOSE_REGISTER)-1:0] release_name_out,
  output logic [$clog2(NUM_ROB_ENTRY)-1:0] release_rob_index_out,
  input  logic [NUM_READ_PORT*$clog2(NUM_ROB_ENTRY)-1:0] read_rob_index_flatted_in,
  output logic [NUM_READ_PORT-1:0] read_done_flatted_out,
  output logic [NUM_READ_PORT*DATA_WIDTH-1:0] read_data_flatted_out
);

  localparam int IW = $clog2(NUM_ROB_ENTRY);
  localparam int RW = $clog2(NUM_GENERAL_PURPOSE_REGISTER);
  localparam int CW = $clog2(NUM_ROB_ENTRY + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_ROB_ENTRY - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_ROB_ENTRY);

  logic                  busy_q     [NUM_ROB_ENTRY];
  logic                  done_q     [NUM_ROB_ENTRY];
  logic                  has_dest_q [NUM_ROB_ENTRY];
  logic [RW-1:0]         dest_q     [NUM_ROB_ENTRY];
  logic [DATA_WIDTH-1:0] data_q     [NUM_ROB_ENTRY];

  logic [IW-1:0] head_q;
  logic [IW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic dispatch_fire;
  logic commit_ok;
  logic commit_fire;
  logic wb_hit;
  logic [IW-1:0] rd_idx;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign dispatch_ready_out     = (count_q != FULL);
  assign dispatch_rob_index_out = tail_q;
  assign dispatch_fire          = dispatch_valid_in & dispatch_ready_out;

  assign wb_hit = writeback_valid_in
                & (32'(writeback_rob_index_in) < NUM_ROB_ENTRY)
                & busy_q[writeback_rob_index_in];

  assign commit_ok   = busy_q[head_q] & done_q[head_q];
  assign commit_fire = commit_ok & commit_ready_in;

  assign commit_valid_out      = commit_ok;
  assign commit_data_out       = commit_ok ? data_q[head_q] : '0;
  assign release_valid_out     = commit_ok & has_dest_q[head_q];
  assign release_name_out      = commit_ok ? dest_q[head_q] : '0;
  assign release_rob_index_out = commit_ok ? head_q : '0;

  // Lookups see registered state only; same-cycle writebacks are not bypassed.
  always_comb begin
    read_done_flatted_out = '0;
    read_data_flatted_out = '0;
    rd_idx = '0;
    for (int p = 0; p < NUM_READ_PORT; p++) begin
      rd_idx = read_rob_index_flatted_in[p*IW +: IW];
      if ((32'(rd_idx) < NUM_ROB_ENTRY) && busy_q[rd_idx] && done_q[rd_idx]) begin
        read_done_flatted_out[p] = 1'b1;
        read_data_flatted_out[p*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
        busy_q[i]     <= 1'b0;
        done_q[i]     <= 1'b0;
        has_dest_q[i] <= 1'b0;
        dest_q[i]     <= '0;
        data_q[i]     <= '0;
      end
    end else if (flush_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
    end else begin
      // Later assignments win: dispatch overrides a writeback to the same slot.
      for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
        if (wb_hit && writeback_rob_index_in == IW'(i)) begin
          done_q[i] <= 1'b1;
          data_q[i] <= writeback_data_in;
        end
        if (commit_fire && head_q == IW'(i)) begin
          busy_q[i]     <= 1'b0;
          done_q[i]     <= 1'b0;
          has_dest_q[i] <= 1'b0;
          dest_q[i]     <= '0;
          data_q[i]     <= '0;
        end
        if (dispatch_fire && tail_q == IW'(i)) begin
          busy_q[i]     <= 1'b1;
          done_q[i]     <= 1'b0;
          has_dest_q[i] <= dispatch_has_dest_in;
          dest_q[i]     <= dispatch_dest_name_in;
        end
      end
      if (dispatch_fire) tail_q <= next_ptr(tail_q);
      if (commit_fire) head_q <= next_ptr(head_q);
      unique case ({dispatch_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, completion, in-order
// retirement, wrap, lookups, flush and asynchronous reset.
module tb_reorder_buffer;

  logic        clk_in;
  logic        reset_in;
  logic        flush_in;
  logic        dispatch_valid_in;
  logic        dispatch_ready_out;
  logic        dispatch_has_dest_in;
  logic [4:0]  dispatch_dest_name_in;
  logic [2:0]  dispatch_rob_index_out;
  logic        writeback_valid_in;
  logic [2:0]  writeback_rob_index_in;
  logic [31:0] writeback_data_in;
  logic        commit_ready_in;
  logic        commit_valid_out;
  logic [31:0] commit_data_out;
  logic        release_valid_out;
  logic [4:0]  release_name_out;
  logic [2:0]  release_rob_index_out;
  logic [5:0]  read_rob_index_flatted_in;
  logic [1:0]  read_done_flatted_out;
  logic [63:0] read_data_flatted_out;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .flush_in(flush_in),
    .dispatch_valid_in(dispatch_valid_in),
    .dispatch_ready_out(dispatch_ready_out),
    .dispatch_has_dest_in(dispatch_has_dest_in),
    .dispatch_dest_name_in(dispatch_dest_name_in),
    .dispatch_rob_index_out(dispatch_rob_index_out),
    .writeback_valid_in(writeback_valid_in),
    .writeback_rob_index_in(writeback_rob_index_in),
    .writeback_data_in(writeback_data_in),
    .commit_ready_in(commit_ready_in),
    .commit_valid_out(commit_valid_out),
    .commit_data_out(commit_data_out),
    .release_valid_out(release_valid_out),
    .release_name_out(release_name_out),
    .release_rob_index_out(release_rob_index_out),
    .read_rob_index_flatted_in(read_rob_index_flatted_in),
    .read_done_flatted_out(read_done_flatted_out),
    .read_data_flatted_out(read_data_flatted_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    flush_in = 1'b0;
    dispatch_valid_in = 1'b0;
    dispatch_has_dest_in = 1'b0;
    dispatch_dest_name_in = '0;
    writeback_valid_in = 1'b0;
    writeback_rob_index_in = '0;
    writeback_data_in = '0;
    commit_ready_in = 1'b0;
    read_rob_index_flatted_in = '0;
    #2;
    checks++;
    if (dispatch_ready_out !== 1'b1 || dispatch_rob_index_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_dispatch got rdy=%b idx=%0d exp rdy=1 idx=0",
               dispatch_ready_out, dispatch_rob_index_out);
    end
    checks++;
    if ({commit_valid_out, commit_data_out, release_valid_out,
         release_name_out, release_rob_index_out} !== '0) begin
      errors++;
      $display("FAIL reset_commit got cv=%b data=%0h rv=%b exp all 0",
               commit_valid_out, commit_data_out, release_valid_out);
    end
    checks++;
    if (read_done_flatted_out !== 2'b00 || read_data_flatted_out !== 64'd0) begin
      errors++;
      $display("FAIL reset_read got done=%b data=%0h exp 0/0",
               read_done_flatted_out, read_data_flatted_out);
    end
    tick();
    tick();
    reset_in = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    dispatch_has_dest_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dispatch_valid_in = 1'b1;
      dispatch_dest_name_in = 5'(i + 1);
      #1;
      checks++;
      if (dispatch_ready_out !== 1'b1 || dispatch_rob_index_out !== 3'(i)) begin
        errors++;
        $display("FAIL fill_grant got rdy=%b idx=%0d exp rdy=1 idx=%0d",
                 dispatch_ready_out, dispatch_rob_index_out, i);
      end
      tick();
    end
    dispatch_dest_name_in = 5'd7;
    #1;
    checks++;
    if (dispatch_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b exp 0", dispatch_ready_out);
    end
    tick();
    checks++;
    if (dut.count_q !== 3'd6 || dispatch_rob_index_out !== 3'd0
        || dispatch_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL stall got count=%0d idx=%0d rdy=%b exp 6/0/0",
               dut.count_q, dispatch_rob_index_out, dispatch_ready_out);
    end
    dispatch_valid_in = 1'b0;
  endtask

  task automatic test_writeback_commit();
    commit_ready_in = 1'b1;
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd2;
    writeback_data_in = 32'hAA;
    #1;
    checks++;
    if (commit_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL wb2_no_commit got %b exp 0", commit_valid_out);
    end
    tick();
    writeback_rob_index_in = 3'd0;
    writeback_data_in = 32'h11;
    #1;
    checks++;
    if (commit_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL wb0_no_bypass got %b exp 0", commit_valid_out);
    end
    tick();
    writeback_valid_in = 1'b0;
    #1;
    checks++;
    if (commit_valid_out !== 1'b1 || release_valid_out !== 1'b1
        || release_name_out !== 5'd1 || commit_data_out !== 32'h11
        || release_rob_index_out !== 3'd0) begin
      errors++;
      $display("FAIL commit0 got cv=%b rv=%b name=%0d data=%0h idx=%0d exp 1/1/1/11/0",
               commit_valid_out, release_valid_out, release_name_out,
               commit_data_out, release_rob_index_out);
    end
    tick();
    checks++;
    if (commit_valid_out !== 1'b0 || dut.count_q !== 3'd5
        || release_rob_index_out !== 3'd0 || commit_data_out !== 32'd0) begin
      errors++;
      $display("FAIL head1_wait got cv=%b count=%0d idx=%0d data=%0h exp 0/5/0/0",
               commit_valid_out, dut.count_q, release_rob_index_out, commit_data_out);
    end
    commit_ready_in = 1'b0;
  endtask

  task automatic test_full_commit_dispatch();
    dispatch_valid_in = 1'b1;
    dispatch_has_dest_in = 1'b1;
    dispatch_dest_name_in = 5'd7;
    #1;
    checks++;
    if (dispatch_ready_out !== 1'b1 || dispatch_rob_index_out !== 3'd0) begin
      errors++;
      $display("FAIL wrap_grant got rdy=%b idx=%0d exp 1/0",
               dispatch_ready_out, dispatch_rob_index_out);
    end
    tick();
    dispatch_valid_in = 1'b0;
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd1;
    writeback_data_in = 32'h22;
    tick();
    writeback_valid_in = 1'b0;
    dispatch_valid_in = 1'b1;
    dispatch_dest_name_in = 5'd8;
    commit_ready_in = 1'b1;
    #1;
    checks++;
    if (dispatch_ready_out !== 1'b0 || commit_valid_out !== 1'b1
        || commit_data_out !== 32'h22 || release_name_out !== 5'd2
        || release_rob_index_out !== 3'd1) begin
      errors++;
      $display("FAIL full_commit got rdy=%b cv=%b data=%0h name=%0d idx=%0d exp 0/1/22/2/1",
               dispatch_ready_out, commit_valid_out, commit_data_out,
               release_name_out, release_rob_index_out);
    end
    tick();
    checks++;
    if (dut.count_q !== 3'd5 || dispatch_ready_out !== 1'b1
        || dispatch_rob_index_out !== 3'd1) begin
      errors++;
      $display("FAIL after_full_commit got count=%0d rdy=%b idx=%0d exp 5/1/1",
               dut.count_q, dispatch_ready_out, dispatch_rob_index_out);
    end
    dispatch_valid_in = 1'b0;
    commit_ready_in = 1'b0;
  endtask

  task automatic test_flush();
    commit_ready_in = 1'b1;
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd3;
    writeback_data_in = 32'h33;
    #1;
    checks++;
    if (commit_data_out !== 32'hAA || release_name_out !== 5'd3) begin
      errors++;
      $display("FAIL commit2 got data=%0h name=%0d exp AA/3",
               commit_data_out, release_name_out);
    end
    tick();
    writeback_valid_in = 1'b0;
    flush_in = 1'b1;
    dispatch_valid_in = 1'b1;
    dispatch_dest_name_in = 5'd9;
    #1;
    checks++;
    if (dut.count_q !== 3'd4 || commit_valid_out !== 1'b1
        || commit_data_out !== 32'h33) begin
      errors++;
      $display("FAIL flush_cycle got count=%0d cv=%b data=%0h exp 4/1/33",
               dut.count_q, commit_valid_out, commit_data_out);
    end
    tick();
    flush_in = 1'b0;
    dispatch_valid_in = 1'b0;
    commit_ready_in = 1'b0;
    read_rob_index_flatted_in = {3'd5, 3'd3};
    #1;
    checks++;
    if (dut.count_q !== 3'd0 || dut.head_q !== 3'd0 || dut.tail_q !== 3'd0
        || dispatch_ready_out !== 1'b1 || commit_valid_out !== 1'b0
        || read_done_flatted_out !== 2'b00) begin
      errors++;
      $display("FAIL flush_state got count=%0d head=%0d tail=%0d rdy=%b cv=%b rd=%b exp 0/0/0/1/0/00",
               dut.count_q, dut.head_q, dut.tail_q, dispatch_ready_out,
               commit_valid_out, read_done_flatted_out);
    end
  endtask

  task automatic test_no_dest();
    dispatch_valid_in = 1'b1;
    dispatch_has_dest_in = 1'b0;
    dispatch_dest_name_in = 5'd9;
    #1;
    checks++;
    if (dispatch_rob_index_out !== 3'd0) begin
      errors++;
      $display("FAIL nodest_grant got %0d exp 0", dispatch_rob_index_out);
    end
    tick();
    dispatch_valid_in = 1'b0;
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd0;
    writeback_data_in = 32'h77;
    tick();
    writeback_valid_in = 1'b0;
    #1;
    checks++;
    if (commit_valid_out !== 1'b1 || release_valid_out !== 1'b0
        || commit_data_out !== 32'h77 || release_rob_index_out !== 3'd0) begin
      errors++;
      $display("FAIL nodest_commit got cv=%b rv=%b data=%0h idx=%0d exp 1/0/77/0",
               commit_valid_out, release_valid_out, commit_data_out,
               release_rob_index_out);
    end
    commit_ready_in = 1'b1;
    tick();
    commit_ready_in = 1'b0;
    #1;
    checks++;
    if (commit_valid_out !== 1'b0 || dut.head_q !== 3'd1 || dut.count_q !== 3'd0
        || dispatch_rob_index_out !== 3'd1) begin
      errors++;
      $display("FAIL nodest_after got cv=%b head=%0d count=%0d idx=%0d exp 0/1/0/1",
               commit_valid_out, dut.head_q, dut.count_q, dispatch_rob_index_out);
    end
  endtask

  task automatic test_read();
    dispatch_has_dest_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dispatch_valid_in = 1'b1;
      dispatch_dest_name_in = 5'(10 + i);
      tick();
    end
    dispatch_valid_in = 1'b0;
    read_rob_index_flatted_in = {3'd3, 3'd3};
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd3;
    writeback_data_in = 32'h55;
    #1;
    checks++;
    if (read_done_flatted_out[0] !== 1'b0 || read_data_flatted_out[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL read_wb_cycle got done=%b data=%0h exp 0/0",
               read_done_flatted_out[0], read_data_flatted_out[31:0]);
    end
    tick();
    writeback_valid_in = 1'b0;
    #1;
    checks++;
    if (read_done_flatted_out !== 2'b11 || read_data_flatted_out[31:0] !== 32'h55
        || read_data_flatted_out[63:32] !== 32'h55) begin
      errors++;
      $display("FAIL read_after_wb got done=%b data=%0h exp 11/55 on both ports",
               read_done_flatted_out, read_data_flatted_out);
    end
    read_rob_index_flatted_in = {3'd4, 3'd3};
    writeback_valid_in = 1'b1;
    writeback_rob_index_in = 3'd4;
    writeback_data_in = 32'h99;
    tick();
    writeback_valid_in = 1'b0;
    #1;
    checks++;
    if (read_done_flatted_out !== 2'b01 || read_data_flatted_out[63:32] !== 32'd0
        || dut.busy_q[4] !== 1'b0) begin
      errors++;
      $display("FAIL wb_empty_ignored got done=%b data1=%0h exp 01/0",
               read_done_flatted_out, read_data_flatted_out[63:32]);
    end
    read_rob_index_flatted_in = {3'd7, 3'd3};
    #1;
    checks++;
    if (read_done_flatted_out[1] !== 1'b0 || read_data_flatted_out[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL read_out_of_range got done=%b data=%0h exp 0/0",
               read_done_flatted_out[1], read_data_flatted_out[63:32]);
    end
    checks++;
    if (commit_valid_out !== 1'b0 || dispatch_rob_index_out !== 3'd4) begin
      errors++;
      $display("FAIL read_side_state got cv=%b idx=%0d exp 0/4",
               commit_valid_out, dispatch_rob_index_out);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk_in);
    #3;
    reset_in = 1'b0;
    #1;
    checks++;
    if (dispatch_ready_out !== 1'b1 || dispatch_rob_index_out !== 3'd0
        || read_done_flatted_out !== 2'b00 || read_data_flatted_out !== 64'd0
        || commit_valid_out !== 1'b0 || dut.count_q !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b idx=%0d rd=%b data=%0h cv=%b count=%0d exp 1/0/00/0/0/0",
               dispatch_ready_out, dispatch_rob_index_out, read_done_flatted_out,
               read_data_flatted_out, commit_valid_out, dut.count_q);
    end
    tick();
    reset_in = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback_commit();
    test_full_commit_dispatch();
    test_flush();
    test_no_dest();
    test_read();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
